// File: rtl/video_source_scheduler.sv
// Shares one display pixel stream among four video sources, handing whole frames
// to requesting sources in round-robin order while tracking the raster position.
module video_source_scheduler #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int DEFAULT_SRC = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VideoReady,
    input  logic [95:0] SrcVideo,
    input  logic [3:0]  SrcReq,
    input  logic        ForceEn,
    input  logic [1:0]  ForceSel,
    output logic [3:0]  SrcGrant,
    output logic [3:0]  SrcReady,
    output logic [23:0] video,
    output logic [9:0]  PixelX,
    output logic [9:0]  PixelY,
    output logic        FrameStart,
    output logic [15:0] FrameCount
);

    localparam logic [1:0] DEF_OWNER = 2'(DEFAULT_SRC);
    localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);

    typedef enum logic {
        STREAM = 1'b0,
        SWITCH = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] owner;
    logic [1:0] next_owner;
    logic [1:0] cand;
    logic       found;
    logic       end_of_line;
    logic       last_pixel;

    assign end_of_line = VideoReady && (PixelX == X_LAST);
    assign last_pixel  = end_of_line && (PixelY == Y_LAST);

    // Rotating search starts just past the current owner, so the owner itself is checked last.
    always_comb begin
        next_owner = DEF_OWNER;
        found      = 1'b0;
        cand       = owner;
        if (ForceEn) begin
            next_owner = ForceSel;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand = owner + 2'(k);
                if (!found && SrcReq[cand]) begin
                    next_owner = cand;
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PixelX     <= '0;
            PixelY     <= '0;
            FrameCount <= '0;
            owner      <= DEF_OWNER;
        end else if (VideoReady) begin
            if (end_of_line) begin
                PixelX <= '0;
                if (last_pixel) begin
                    PixelY     <= '0;
                    FrameCount <= FrameCount + 16'd1;
                    owner      <= next_owner;
                end else begin
                    PixelY <= PixelY + 10'd1;
                end
            end else begin
                PixelX <= PixelX + 10'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    // SWITCH only marks an ownership handover; it never stalls the pixel flow.
    always_comb begin
        state_d = STREAM;
        case (state_q)
            STREAM:  if (last_pixel && (next_owner != owner)) state_d = SWITCH;
            SWITCH:  state_d = STREAM;
            default: state_d = STREAM;
        endcase
    end

    always_comb begin
        video = SrcVideo[23:0];
        case (owner)
            2'd0: video = SrcVideo[23:0];
            2'd1: video = SrcVideo[47:24];
            2'd2: video = SrcVideo[71:48];
            2'd3: video = SrcVideo[95:72];
            default: video = SrcVideo[23:0];
        endcase
    end

    assign SrcGrant   = 4'b0001 << owner;
    assign SrcReady   = {4{VideoReady}} & SrcGrant;
    assign FrameStart = (PixelX == 10'd0) && (PixelY == 10'd0);

endmodule

// File: tb/tb_video_source_scheduler.sv
// Directed bench for video_source_scheduler: a 4x2 raster instance for arbitration
// and raster checks, and a 1x1 instance that wraps FrameCount quickly.
module tb_video_source_scheduler;

    logic        clk;
    logic        rst;
    logic        video_ready;
    logic [95:0] src_video;
    logic [3:0]  src_req;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [3:0]  src_grant;
    logic [3:0]  src_ready;
    logic [23:0] video;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic [15:0] frame_count;

    logic        video_ready2;
    logic [3:0]  src_grant2;
    logic [3:0]  src_ready2;
    logic [23:0] video2;
    logic [9:0]  pixel_x2;
    logic [9:0]  pixel_y2;
    logic        frame_start2;
    logic [15:0] frame_count2;

    int check_count = 0;
    int pass_count  = 0;

    logic [23:0] vids [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};

    video_source_scheduler #(.H_ACTIVE(4), .V_ACTIVE(2), .DEFAULT_SRC(0)) dut (
        .Clock(clk), .Reset(rst), .VideoReady(video_ready), .SrcVideo(src_video),
        .SrcReq(src_req), .ForceEn(force_en), .ForceSel(force_sel),
        .SrcGrant(src_grant), .SrcReady(src_ready), .video(video),
        .PixelX(pixel_x), .PixelY(pixel_y), .FrameStart(frame_start),
        .FrameCount(frame_count)
    );

    video_source_scheduler #(.H_ACTIVE(1), .V_ACTIVE(1), .DEFAULT_SRC(0)) dut_wrap (
        .Clock(clk), .Reset(rst), .VideoReady(video_ready2), .SrcVideo(src_video),
        .SrcReq(4'b0000), .ForceEn(1'b0), .ForceSel(2'd0),
        .SrcGrant(src_grant2), .SrcReady(src_ready2), .video(video2),
        .PixelX(pixel_x2), .PixelY(pixel_y2), .FrameStart(frame_start2),
        .FrameCount(frame_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        src_req = 4'b0100;
        video_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_count++;
        if (src_grant !== 4'b0100) $display("[TB] FAIL pre_reset_grant: got %b expected %b", src_grant, 4'b0100);
        else pass_count++;
        for (int i = 0; i < 5; i++) tick();
        check_count++;
        if (pixel_x !== 10'd1 || pixel_y !== 10'd1) $display("[TB] FAIL pre_reset_pos: got %0d,%0d expected 1,1", pixel_x, pixel_y);
        else pass_count++;
        video_ready = 1'b0;
        src_req = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check_count++;
        if (pixel_x !== 10'd0 || pixel_y !== 10'd0) $display("[TB] FAIL reset_pos: got %0d,%0d expected 0,0", pixel_x, pixel_y);
        else pass_count++;
        check_count++;
        if (src_grant !== 4'b0001) $display("[TB] FAIL reset_grant: got %b expected %b", src_grant, 4'b0001);
        else pass_count++;
        check_count++;
        if (frame_start !== 1'b1) $display("[TB] FAIL reset_frame_start: got %b expected 1", frame_start);
        else pass_count++;
        check_count++;
        if (frame_count !== 16'd0) $display("[TB] FAIL reset_frame_count: got %0d expected 0", frame_count);
        else pass_count++;
        check_count++;
        if (src_ready !== 4'b0000) $display("[TB] FAIL reset_src_ready: got %b expected 0000", src_ready);
        else pass_count++;
        check_count++;
        if (video !== 24'h111111) $display("[TB] FAIL reset_video: got %h expected %h", video, 24'h111111);
        else pass_count++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_default_stream();
        do_reset();
        src_req = 4'b0000;
        force_en = 1'b0;
        video_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check_count++;
            if (pixel_x !== 10'(n % 4) || pixel_y !== 10'((n / 4) % 2))
                $display("[TB] FAIL default_pos n=%0d: got %0d,%0d expected %0d,%0d", n, pixel_x, pixel_y, n % 4, (n / 4) % 2);
            else pass_count++;
            check_count++;
            if (frame_start !== (n % 8 == 0)) $display("[TB] FAIL default_frame_start n=%0d: got %b expected %b", n, frame_start, (n % 8 == 0));
            else pass_count++;
            check_count++;
            if (frame_count !== 16'(n / 8)) $display("[TB] FAIL default_frame_count n=%0d: got %0d expected %0d", n, frame_count, n / 8);
            else pass_count++;
            check_count++;
            if (src_grant !== 4'b0001 || video !== 24'h111111)
                $display("[TB] FAIL default_owner n=%0d: got %b/%h expected 0001/111111", n, src_grant, video);
            else pass_count++;
            if (n == 8) begin
                check_count++;
                if (dut.state_q !== 1'b0) $display("[TB] FAIL default_no_switch: got %b expected 0", dut.state_q);
                else pass_count++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_owner [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [1:0] cur;
        do_reset();
        src_req = 4'b1010;
        video_ready = 1'b1;
        cur = 2'd0;
        for (int f = 0; f < 4; f++) begin
            for (int t = 1; t <= 8; t++) begin
                tick();
                if (t == 1 && f > 0) begin
                    check_count++;
                    if (dut.state_q !== 1'b0) $display("[TB] FAIL rr_switch_exit f=%0d: got %b expected 0", f, dut.state_q);
                    else pass_count++;
                end
                if (t == 4) begin
                    check_count++;
                    if (src_ready !== (4'b0001 << cur)) $display("[TB] FAIL rr_src_ready f=%0d: got %b expected %b", f, src_ready, 4'b0001 << cur);
                    else pass_count++;
                end
            end
            cur = exp_owner[f];
            check_count++;
            if (src_grant !== (4'b0001 << cur)) $display("[TB] FAIL rr_grant f=%0d: got %b expected %b", f, src_grant, 4'b0001 << cur);
            else pass_count++;
            check_count++;
            if (dut.state_q !== 1'b1) $display("[TB] FAIL rr_switch f=%0d: got %b expected 1", f, dut.state_q);
            else pass_count++;
            check_count++;
            if (video !== vids[cur]) $display("[TB] FAIL rr_video f=%0d: got %h expected %h", f, video, vids[cur]);
            else pass_count++;
        end
    endtask

    task automatic test_midframe_request();
        do_reset();
        src_req = 4'b0000;
        video_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        src_req = 4'b0100;
        for (int i = 0; i < 2; i++) tick();
        src_req = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        check_count++;
        if (src_grant !== 4'b0001) $display("[TB] FAIL midframe_drop_grant: got %b expected 0001", src_grant);
        else pass_count++;
        src_req = 4'b0100;
        for (int i = 0; i < 8; i++) tick();
        check_count++;
        if (src_grant !== 4'b0100) $display("[TB] FAIL midframe_hold_grant: got %b expected 0100", src_grant);
        else pass_count++;
        check_count++;
        if (video !== 24'h333333 || frame_start !== 1'b1)
            $display("[TB] FAIL midframe_first_pixel: got %h/%b expected 333333/1", video, frame_start);
        else pass_count++;
    endtask

    task automatic test_force();
        src_req = 4'b0110;
        force_en = 1'b1;
        force_sel = 2'd3;
        for (int i = 0; i < 8; i++) tick();
        check_count++;
        if (src_grant !== 4'b1000) $display("[TB] FAIL force_grant: got %b expected 1000", src_grant);
        else pass_count++;
        check_count++;
        if (video !== 24'h444444) $display("[TB] FAIL force_video: got %h expected 444444", video);
        else pass_count++;
        force_en = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_count++;
        if (src_grant !== 4'b0010) $display("[TB] FAIL force_release_grant: got %b expected 0010", src_grant);
        else pass_count++;
    endtask

    task automatic test_ready_gaps();
        logic       pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [9:0] exp_x   [4] = '{10'd1, 10'd1, 10'd1, 10'd2};
        for (int i = 0; i < 4; i++) begin
            video_ready = pattern[i];
            #1;
            check_count++;
            if (src_ready !== (pattern[i] ? 4'b0010 : 4'b0000))
                $display("[TB] FAIL gap_src_ready i=%0d: got %b expected %b", i, src_ready, pattern[i] ? 4'b0010 : 4'b0000);
            else pass_count++;
            tick();
            check_count++;
            if (pixel_x !== exp_x[i]) $display("[TB] FAIL gap_pixel_x i=%0d: got %0d expected %0d", i, pixel_x, exp_x[i]);
            else pass_count++;
        end
        video_ready = 1'b0;
    endtask

    task automatic test_frame_wrap();
        do_reset();
        video_ready2 = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        check_count++;
        if (frame_count2 !== 16'hFFFF) $display("[TB] FAIL wrap_pre: got %h expected FFFF", frame_count2);
        else pass_count++;
        check_count++;
        if (frame_start2 !== 1'b1 || pixel_x2 !== 10'd0) $display("[TB] FAIL wrap_raster: got %b/%0d expected 1/0", frame_start2, pixel_x2);
        else pass_count++;
        tick();
        check_count++;
        if (frame_count2 !== 16'h0000) $display("[TB] FAIL wrap_post: got %h expected 0000", frame_count2);
        else pass_count++;
        video_ready2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        video_ready = 1'b0;
        video_ready2 = 1'b0;
        src_video = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        src_req = 4'b0000;
        force_en = 1'b0;
        force_sel = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_default_stream();
        test_round_robin();
        test_midframe_request();
        test_force();
        test_ready_gaps();
        test_frame_wrap();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/video_source_scheduler.md
Name: video_source_scheduler

Overview:
- Shares the display's pixel stream between four video sources: the pattern generator, the SIFT keypoint overlay, the frame-buffer reader and a debug source.
- Tracks raster position by counting VideoReady pulses and hands ownership of whole frames to requesting sources with round-robin arbitration.
- Routes the owner's 24-bit RGB onto video and forwards VideoReady only to the owner.
- Sits between the sources and the display/DVI front end.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- DEFAULT_SRC, 0, source index owning the frame when no source requests (pattern generator).

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- VideoReady  input  1  display consumes one pixel this cycle
- SrcVideo  input  96  source i RGB at bits [24*i+23:24*i], {R,G,B}
- SrcReq  input  4  source i requests ownership of upcoming frames (level)
- ForceEn  input  1  override arbitration at next frame boundary
- ForceSel  input  2  source index used when ForceEn
- SrcGrant  output  4  one-hot current frame owner
- SrcReady  output  4  VideoReady gated to owner: SrcReady[i] = VideoReady & SrcGrant[i]
- video  output  24  owner's SrcVideo slice, combinational mux
- PixelX  output  10  current column, 0..H_ACTIVE-1
- PixelY  output  10  current line, 0..V_ACTIVE-1
- FrameStart  output  1  high while PixelX==0 and PixelY==0
- FrameCount  output  16  completed frames, wraps 16'hFFFF -> 0

Behaviour:
- Reset (any time, including mid-frame): PixelX=0, PixelY=0, FrameCount=0, owner=DEFAULT_SRC, so SrcGrant=one-hot(DEFAULT_SRC) and FrameStart=1.
- After reset, SrcReady=0 and video=SrcVideo[DEFAULT_SRC] as soon as inputs allow.
- Raster counting, on each cycle with VideoReady=1:
  - PixelX increments.
  - At PixelX==H_ACTIVE-1: PixelX -> 0 and PixelY increments.
  - At PixelY==V_ACTIVE-1 on that same last column: PixelY -> 0, FrameCount increments, and the frame ends.
  - VideoReady=0: all registers hold.
- LastPixel = VideoReady & (PixelX==H_ACTIVE-1) & (PixelY==V_ACTIVE-1).
- State machine, two states:
  - STREAM: normal streaming.
  - SWITCH: one-cycle marker entered on LastPixel when the new owner differs from the old one. Exits unconditionally to STREAM next cycle. The owner register is already updated in SWITCH.
  - SWITCH exists only for observability and for future blanking; pixel flow is not stalled. VideoReady during SWITCH counts as the new frame's first pixel, served by the new owner.
- Arbitration is evaluated only in the LastPixel cycle, using SrcReq, ForceEn and ForceSel sampled in that cycle. Priority order:
  1. ForceEn=1: new owner = ForceSel, regardless of SrcReq.
  2. Any SrcReq set: first set bit searching (owner+1) mod 4, (owner+2) mod 4, (owner+3) mod 4, owner.
  3. No requests: new owner = DEFAULT_SRC.
- The owner register updates at the LastPixel clock edge, so pixel (0,0) of the next frame comes from the new owner.
- SrcReq changes mid-frame have no effect. Ownership is never revoked mid-frame, even if the owner deasserts SrcReq.
- An owner that keeps requesting while others also request loses the frame to the next requester in rotation (fairness).
- Width rules:
  - PixelX and PixelY are 10 bits; H_ACTIVE and V_ACTIVE must be ≤1024.
  - FrameCount wraps modulo 2^16 with no saturation.
- video and SrcReady are purely combinational from the owner register and inputs, with zero-cycle latency.

Test Plan:
1. Reset asserted mid-frame at PixelX=37, PixelY=5 with owner=2 -> immediately PixelX=0, PixelY=0, SrcGrant=4'b0001, FrameStart=1, FrameCount=0.
2. H_ACTIVE=4, V_ACTIVE=2, SrcReq=0, VideoReady held high -> FrameStart pulses every 8 cycles, FrameCount increments each 8th cycle, SrcGrant stays 4'b0001, video equals SrcVideo[23:0].
3. SrcReq=4'b1010 held, owner=0 -> successive frame owners 1,3,1,3. SrcReady[1] pulses only during owner-1 frames. SWITCH is visited at every boundary.
4. SrcReq rises for source 2 mid-frame and falls before the last pixel -> no ownership change. SrcReq held through LastPixel -> source 2 owns next frame and pixel (0,0) shows SrcVideo[71:48].
5. ForceEn=1, ForceSel=3 with SrcReq=4'b0110 at LastPixel -> owner=3. ForceEn=0 at the next boundary -> round-robin from 3 grants source 1.
6. VideoReady toggled 1,0,0,1 -> PixelX advances only on the 1 cycles. FrameCount wraps 16'hFFFF -> 16'h0000 after 65536 frames (forced preload via a short-frame configuration).
